// File: rtl/divider_cfg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_cfg_ctrl_pkg
//  Description : Shared state encoding, parameter defaults and sizing helper
//                for the divider configuration sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package divider_cfg_ctrl_pkg;

    localparam int unsigned c_GATE_CYC_DEF  = 2;
    localparam int unsigned c_RST_CYC_DEF   = 1;
    localparam int unsigned c_DEFAULT_N_DEF = 2;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_ALIGN = 3'd3,
        ST_GATE  = 3'd4,
        ST_LOAD  = 3'd5
    } cfg_state_t;

    // Width of the shared GATE/LOAD down-counter; it holds at most max-1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/divider_cfg_ctrl_phase_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : divider_cfg_ctrl_phase_tracker
//  Description : Mirrors the divider output period. Counts 0..div_n-1 while
//                the divider runs and flags the last cycle of each period so
//                reconfiguration can land on a period boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_cfg_ctrl_phase_tracker #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             ref_clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic [WIDTH-1:0] div_n,
    output logic             at_boundary
);

    logic [WIDTH-1:0] r_phase;
    logic             w_bypass;
    logic             w_wrap;

    // Ratios below 2 bypass the divider, so every cycle is a boundary.
    assign w_bypass    = (div_n < WIDTH'(2));
    assign w_wrap      = (r_phase == (div_n - WIDTH'(1)));
    assign at_boundary = w_bypass || w_wrap;

    // Phase counter: restarts whenever the divider is not running.
    always_ff @(posedge ref_clk) begin
        if (!reset) begin
            r_phase <= '0;
        end else if (!count_en || w_bypass || w_wrap) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/divider_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : divider_cfg_ctrl
//  Description : Run-time configuration sequencer for the adjustable-N clock
//                divider. Applies new ratios glitch-free (align, gate enable,
//                pulse reset while loading, restart) and starts/stops the
//                divider from run_en.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_cfg_ctrl
    import divider_cfg_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned GATE_CYC  = c_GATE_CYC_DEF,
    parameter int unsigned RST_CYC   = c_RST_CYC_DEF,
    parameter int unsigned DEFAULT_N = c_DEFAULT_N_DEF
) (
    input  logic             ref_clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_n,
    output logic             req_ready,
    output logic             req_err,
    output logic             div_enable,
    output logic [WIDTH-1:0] div_n,
    output logic             div_reset,
    output logic             busy,
    output logic             cfg_done
);

    localparam int unsigned      c_CNT_W   = cnt_width(GATE_CYC, RST_CYC);
    localparam logic [c_CNT_W-1:0] c_GATE_LD = c_CNT_W'(GATE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_RST_LD  = c_CNT_W'(RST_CYC - 1);
    localparam logic [WIDTH-1:0] c_DEF_N   = WIDTH'(DEFAULT_N);

    cfg_state_t         r_state;
    cfg_state_t         w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_div_n;
    logic [WIDTH-1:0]   r_pend_n;
    logic               r_pend_vld;
    logic               r_stop;
    logic               r_reconf;
    logic               r_req_ready;
    logic               r_req_err;
    logic               r_div_enable;
    logic               r_div_reset;
    logic               r_busy;
    logic               r_cfg_done;

    logic               w_accept;
    logic               w_legal;
    logic               w_cnt_zero;
    logic               w_count_en;
    logic               w_at_boundary;
    logic               w_enter_gate;
    logic               w_enter_load;

    assign w_accept     = req_valid && r_req_ready;
    assign w_legal      = w_accept && (req_n != '0);
    assign w_cnt_zero   = (r_cnt == '0);
    assign w_count_en   = (r_state == ST_RUN) || (r_state == ST_ALIGN);
    assign w_enter_gate = (w_next == ST_GATE) && (r_state != ST_GATE);
    assign w_enter_load = (w_next == ST_LOAD) && (r_state != ST_LOAD);

    divider_cfg_ctrl_phase_tracker #(
        .WIDTH (WIDTH)
    ) u_phase (
        .ref_clk     (ref_clk),
        .reset       (reset),
        .count_en    (w_count_en),
        .div_n       (r_div_n),
        .at_boundary (w_at_boundary)
    );

    // Next-state selection; a stop request always beats a reconfiguration.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OFF:   if (run_en) w_next = ST_START;
            ST_START: w_next = ST_RUN;
            ST_RUN: begin
                if (!run_en)      w_next = ST_GATE;
                else if (w_legal) w_next = ST_ALIGN;
            end
            ST_ALIGN: if (!run_en || w_at_boundary) w_next = ST_GATE;
            ST_GATE: begin
                if (w_cnt_zero) w_next = r_pend_vld ? ST_LOAD : ST_OFF;
            end
            ST_LOAD: begin
                if (w_cnt_zero) w_next = r_stop ? ST_OFF : ST_START;
            end
            default:  w_next = ST_OFF;
        endcase
    end

    // State, bookkeeping and registered outputs decoded from the next state.
    always_ff @(posedge ref_clk) begin
        if (!reset) begin
            r_state      <= ST_OFF;
            r_cnt        <= '0;
            r_div_n      <= c_DEF_N;
            r_pend_n     <= '0;
            r_pend_vld   <= 1'b0;
            r_stop       <= 1'b0;
            r_reconf     <= 1'b0;
            r_req_ready  <= 1'b1;
            r_req_err    <= 1'b0;
            r_div_enable <= 1'b0;
            r_div_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_cfg_done   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_req_ready  <= (w_next == ST_OFF) || (w_next == ST_RUN);
            r_div_enable <= (w_next == ST_RUN) || (w_next == ST_ALIGN);
            r_div_reset  <= (w_next == ST_OFF) || (w_next == ST_LOAD);
            r_busy       <= (w_next == ST_ALIGN) || (w_next == ST_GATE) ||
                            (w_next == ST_LOAD)  || (w_next == ST_START);
            r_req_err    <= w_accept && (req_n == '0);
            r_cfg_done   <= (r_state == ST_START) && r_reconf;

            // One down-counter times both the GATE and LOAD dwell.
            if (w_enter_gate) begin
                r_cnt <= c_GATE_LD;
            end else if (w_enter_load) begin
                r_cnt <= c_RST_LD;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end

            // div_n moves only while the divider is held off or in reset.
            if ((r_state == ST_OFF) && w_legal) begin
                r_div_n <= req_n;
            end else if (w_enter_load) begin
                r_div_n <= r_pend_n;
            end

            if ((r_state == ST_RUN) && w_legal) begin
                r_pend_n   <= req_n;
                r_pend_vld <= 1'b1;
            end else if (w_enter_load) begin
                r_pend_vld <= 1'b0;
            end

            if (w_count_en && !run_en) begin
                r_stop <= 1'b1;
            end else if (w_next == ST_OFF) begin
                r_stop <= 1'b0;
            end

            // Reconfig marker: survives to START only on the non-stop path.
            if (w_enter_load) begin
                r_reconf <= 1'b1;
            end else if ((r_state == ST_START) || (w_next == ST_OFF)) begin
                r_reconf <= 1'b0;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign req_err    = r_req_err;
    assign div_enable = r_div_enable;
    assign div_n      = r_div_n;
    assign div_reset  = r_div_reset;
    assign busy       = r_busy;
    assign cfg_done   = r_cfg_done;

endmodule
`default_nettype wire
